// File: rtl/beeper_pkg.sv
// Shared definitions for the beep-pattern generator: state encoding and width helpers.
package beeper_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TONE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // Clock cycles per millisecond.
    function automatic int unsigned clk_ms(input int unsigned clk_freq);
        return clk_freq / 1000;
    endfunction

    // ceil(log2(v)); 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        for (int i = 0; i < 32; i++) begin
            if ((x >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_tone_gen.sv
// Square-wave divider. Output idles high (silent) whenever not enabled, so it can
// drive the active-low buzzer directly; a load starts a fresh tone at 0.
module mod_tone_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] half_period,
    output logic             tone
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload_val;

    // Half period of 0 behaves like 1.
    assign reload_val = (half_period == '0) ? '0 : half_period - DIV_W'(1);

    // Divider count-down and tone toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tone <= 1'b1;
        end else if (load) begin
            cnt  <= reload_val;
            tone <= 1'b0;
        end else if (en) begin
            if (cnt == '0) begin
                cnt  <= reload_val;
                tone <= ~tone;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end else begin
            tone <= 1'b1;
        end
    end

endmodule

// File: rtl/mod_beeper.sv
// Beep-pattern generator: plays `repeats` tones of `on_ms` separated by `off_ms` gaps.
module mod_beeper
    import beeper_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned MS_W     = 12,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] half_period,
    input  logic [MS_W-1:0]  on_ms,
    input  logic [MS_W-1:0]  off_ms,
    input  logic [CNT_W-1:0] repeats,
    output logic             buzz,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CLK_MS = clk_ms(CLK_FREQ);
    localparam int unsigned PS_W   = (clog2(CLK_MS) > 0) ? clog2(CLK_MS) : 1;
    localparam logic [PS_W-1:0] PS_TOP = PS_W'(CLK_MS - 1);

    logic [1:0]       state, state_d;
    logic [DIV_W-1:0] hp_q;
    logic [MS_W-1:0]  on_q, off_q;
    logic [CNT_W-1:0] rep_q;
    logic [PS_W-1:0]  ps;
    logic [MS_W-1:0]  ms_cnt;

    logic             accept;
    logic             phase_end;
    logic             load_tone;
    logic             enter_gap;
    logic             tone_en;
    logic [DIV_W-1:0] hp_src;
    logic [MS_W-1:0]  on_src;

    // Operands come straight from the inputs on the start edge, from shadows afterwards.
    assign hp_src    = (state == ST_IDLE) ? half_period : hp_q;
    assign on_src    = (state == ST_IDLE) ? on_ms : on_q;
    assign accept    = (state == ST_IDLE) && start && !abort;
    assign phase_end = (ps == '0) && (ms_cnt == '0);

    // Next-state and phase-control decode.
    always_comb begin
        state_d   = state;
        load_tone = 1'b0;
        enter_gap = 1'b0;
        tone_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (repeats == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d   = ST_TONE;
                        load_tone = 1'b1;
                    end
                end
            end
            ST_TONE: begin
                tone_en = !phase_end;
                if (phase_end) begin
                    if (rep_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end else if (off_q == '0) begin
                        state_d   = ST_TONE;
                        load_tone = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        enter_gap = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_d   = ST_TONE;
                    load_tone = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            load_tone = 1'b0;
            enter_gap = 1'b0;
            tone_en   = 1'b0;
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d == ST_TONE) || (state_d == ST_GAP);
            done  <= (state_d == ST_FIN);
        end
    end

    // Operand shadows, remaining-beep count, ms prescaler and ms counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q   <= '0;
            on_q   <= '0;
            off_q  <= '0;
            rep_q  <= '0;
            ps     <= '0;
            ms_cnt <= '0;
        end else begin
            if (accept) begin
                hp_q  <= half_period;
                on_q  <= on_ms;
                off_q <= off_ms;
                rep_q <= repeats;
            end
            if ((state == ST_TONE) && phase_end && !abort) begin
                rep_q <= rep_q - CNT_W'(1);
            end
            if (load_tone) begin
                ps     <= PS_TOP;
                ms_cnt <= (on_src == '0) ? '0 : on_src - MS_W'(1);
            end else if (enter_gap) begin
                ps     <= PS_TOP;
                ms_cnt <= off_q - MS_W'(1);
            end else if (((state == ST_TONE) || (state == ST_GAP)) && !phase_end && !abort) begin
                if (ps == '0) begin
                    ps     <= PS_TOP;
                    ms_cnt <= ms_cnt - MS_W'(1);
                end else begin
                    ps <= ps - PS_W'(1);
                end
            end
        end
    end

    mod_tone_gen #(
        .DIV_W(DIV_W)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .load       (load_tone),
        .en         (tone_en),
        .half_period(hp_src),
        .tone       (buzz)
    );

endmodule

// File: tb/tb_mod_beeper.sv
// Directed bench for mod_beeper with CLK_FREQ = 10_000 (10 cycles per ms).
module tb_mod_beeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] half_period;
    logic [11:0] on_ms;
    logic [11:0] off_ms;
    logic [3:0]  repeats;
    logic        buzz;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    mod_beeper #(
        .CLK_FREQ(10_000),
        .DIV_W   (16),
        .MS_W    (12),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .half_period(half_period),
        .on_ms      (on_ms),
        .off_ms     (off_ms),
        .repeats    (repeats),
        .buzz       (buzz),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One start pulse, then compare every cycle against a cycle-indexed model.
    // Operands are scrambled right after start; optional stray start at cycle 15 and abort.
    task automatic run_pattern(input string tag, input int hp, input int on, input int off,
                               input int rep, input int ncyc, input bit extra_start,
                               input int abort_cyc);
        int busy_len, eff_len, per, p, hpe;
        int busy_cnt, done_cnt, done_idx, buzz_err, busy_err;
        logic exp_buzz, exp_busy;
        busy_len = (rep == 0) ? 0 : rep * on * 10 + (rep - 1) * off * 10;
        eff_len  = (abort_cyc != 0) ? abort_cyc : busy_len;
        per      = on * 10 + off * 10;
        hpe      = (hp == 0) ? 1 : hp;
        busy_cnt = 0; done_cnt = 0; done_idx = 0; buzz_err = 0; busy_err = 0;
        @(negedge clk);
        half_period = 16'(hp);
        on_ms       = 12'(on);
        off_ms      = 12'(off);
        repeats     = 4'(rep);
        start       = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= ncyc; i++) begin
            exp_busy = (i <= eff_len);
            if (!exp_busy) begin
                exp_buzz = 1'b1;
            end else begin
                p = (i - 1) % per;
                exp_buzz = (p >= on * 10) ? 1'b1 : (((p / hpe) % 2) != 0);
            end
            if (buzz !== exp_buzz) buzz_err++;
            if (busy !== exp_busy) busy_err++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_idx == 0) done_idx = i;
            end
            if (i == 1) begin
                start       = 1'b0;
                half_period = 16'd7;
                on_ms       = 12'd3;
                off_ms      = 12'd2;
                repeats     = 4'd5;
            end
            if (extra_start && i == 15) start = 1'b1;
            if (extra_start && i == 16) start = 1'b0;
            if (abort_cyc != 0 && i == abort_cyc) abort = 1'b1;
            if (abort_cyc != 0 && i == abort_cyc + 1) abort = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        chk({tag, "_busy_cycles"}, busy_cnt, eff_len);
        chk({tag, "_busy_trace_errs"}, busy_err, 0);
        chk({tag, "_buzz_trace_errs"}, buzz_err, 0);
        if (abort_cyc != 0) begin
            chk({tag, "_done_count"}, done_cnt, 0);
        end else begin
            chk({tag, "_done_count"}, done_cnt, 1);
            chk({tag, "_done_cycle"}, done_idx, busy_len + 1);
        end
    endtask

    initial begin
        int cnt_busy, cnt_done, cnt_buzz0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        half_period = '0; on_ms = '0; off_ms = '0; repeats = '0;
        repeat (3) @(negedge clk);
        chk("reset_buzz", 32'(buzz), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_pattern("r3_on2_off1_hp5", 5, 2, 1, 3, 95, 1'b0, 0);
        run_pattern("r2_on1_off0_hp3", 3, 1, 0, 2, 30, 1'b0, 0);
        run_pattern("r0",              5, 2, 1, 0, 10, 1'b0, 0);
        run_pattern("hp0",             0, 1, 0, 1, 15, 1'b0, 0);
        run_pattern("stray_start",     5, 2, 1, 3, 95, 1'b1, 0);
        run_pattern("abort30",         5, 2, 1, 3, 45, 1'b0, 30);

        // start together with abort in idle stays idle
        @(negedge clk);
        half_period = 16'd4; on_ms = 12'd1; off_ms = 12'd1; repeats = 4'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        cnt_busy = 0; cnt_done = 0; cnt_buzz0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0) cnt_busy++;
            if (done !== 1'b0) cnt_done++;
            if (buzz !== 1'b1) cnt_buzz0++;
            @(negedge clk);
        end
        chk("start_abort_busy", cnt_busy, 0);
        chk("start_abort_done", cnt_done, 0);
        chk("start_abort_buzz", cnt_buzz0, 0);

        // asynchronous reset in the middle of a tone
        @(negedge clk);
        half_period = 16'd5; on_ms = 12'd5; off_ms = 12'd0; repeats = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_buzz", 32'(buzz), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_buzz", 32'(buzz), 1);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_beeper.md
# mod_beeper

Parametrised beep-pattern generator for the music player's audio alert path. On a `start` pulse it plays `repeats` beeps. Each beep is a square-wave tone of programmable pitch lasting `on_ms` milliseconds, and consecutive beeps are separated by a silent gap of `off_ms` milliseconds. It serves the wrong-password alarm, key-click and end-of-track cues, and drives the active-low buzzer pin directly.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz; `CLK_MS = CLK_FREQ/1000` cycles per millisecond.
- `DIV_W`, 16: width of the tone half-period operand.
- `MS_W`, 12: width of the duration operands, in ms.
- `CNT_W`, 4: width of the beep-count operand.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  stops the pattern immediately; has priority over `start`.
- `half_period`  in  DIV_W  clock cycles per half tone period; 0 is treated as 1.
- `on_ms`  in  MS_W  tone duration in ms; 0 is treated as 1.
- `off_ms`  in  MS_W  gap duration in ms; 0 means no gap.
- `repeats`  in  CNT_W  number of beeps; 0 means no beep, `done` only.
- `buzz`  out  1  buzzer drive, active-low; 1 = silent.
- `busy`  out  1  pattern in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, TONE, GAP, FIN.
- IDLE:
  - On `start`, latch `half_period`, `on_ms`, `off_ms` and `repeats` into shadow registers. Input changes after that point have no effect until the next start.
  - `repeats`=0 goes to FIN; otherwise go to TONE.
- TONE:
  - On entry, load the ms prescaler (CLK_MS-1), the ms counter and the tone divider, and drive `buzz`=0.
  - `buzz` toggles every `half_period` cycles.
  - When the ms count expires, decrement the remaining-beep count. If it is now 0, go to FIN. Otherwise go to GAP, or to TONE again if `off_ms`=0.
  - Re-entering TONE restarts the tone phase with `buzz`=0.
- GAP: `buzz`=1 for `off_ms`·CLK_MS cycles, then go to TONE.
- FIN: lasts one cycle, with `done`=1, `busy`=0 and `buzz`=1, then go to IDLE.
- `busy`=1 exactly in TONE and GAP.
- `abort`: from any state, go to IDLE on the next edge with `buzz`=1, `busy`=0 and no `done`. `abort` together with `start` in IDLE: remain in IDLE.
- `start` while busy is ignored; no queueing.
- Counters:
  - The prescaler is ceil(log2(CLK_MS)) bits.
  - The ms counter is MS_W bits and counts down.
  - The tone divider is DIV_W bits and counts down.
  - No counter wraps; each reloads on phase entry.
- Reset: IDLE, `buzz`=1, `busy`=0, `done`=0, all counters 0.

## Timing
- All outputs are registered.
- `start` high at edge k: from cycle k+1, `busy`=1 and `buzz`=0.
- Each TONE phase lasts exactly `on_ms`·CLK_MS cycles. Each GAP phase lasts exactly `off_ms`·CLK_MS cycles.
- Total busy cycles = R·on·CLK_MS + (R-1)·off·CLK_MS, where R=`repeats`. There is no trailing gap.
- `done` is high in the first cycle after the last TONE cycle, coincident with `busy` falling. With `repeats`=0, `done` is high in cycle k+1 and `busy` stays 0.
- A new `start` is accepted in the FIN cycle's successor, i.e. in IDLE, at the earliest.
- A tone toggle that coincides with the phase end is suppressed; the phase transition wins.

## Structure
- Shared package `beeper_pkg` holds:
  - the state encoding (IDLE, TONE, GAP, FIN);
  - the `CLK_MS` derivation;
  - the `clog2` width helper.
- One sub-module, `mod_tone_gen`:
  - ports: `clk`, `rst`, `load`, `en`, `half_period`, `tone`;
  - reloads on `load` with `tone`=0, toggles every `half_period` enabled cycles.
- The FSM, ms prescaler and counters stay in `mod_beeper`.

## Test plan
All scenarios use CLK_FREQ=10_000, so CLK_MS=10.
- Reset mid-TONE: assert `rst` asynchronously → `buzz`=1, `busy`=0, `done`=0 immediately, with no clock edge needed.
- `repeats`=3, `on_ms`=2, `off_ms`=1, `half_period`=5:
  - `busy` high for 80 cycles;
  - three 20-cycle tones, each `buzz` 0,1,0,1 in 5-cycle runs;
  - 10-cycle gaps with `buzz`=1;
  - `done` in cycle 81.
- `repeats`=2, `off_ms`=0, `on_ms`=1, `half_period`=3: 20 busy cycles; `buzz` restarts at 0 at cycle 11; `done` at cycle 21.
- `repeats`=0 → `done` at cycle k+1, `busy` never high, `buzz` stays 1. `half_period`=0 → `buzz` toggles every cycle.
- `start` at cycle 15 while busy: ignored, and total length is unchanged. `abort` at cycle 30 → IDLE at 31, no `done`. `start`+`abort` together in IDLE → stays idle.
- Change the operands one cycle after `start` → pattern timing matches the originally latched values.
